// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// FSM state codes, bus-owner codes and the starvation counter width helper.
package imem_dmem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } arb_owner_t;

  // Width needed to hold 0..max_val inclusive (at least one bit).
  function automatic int starve_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive fetch losses. sat_o tells the arbiter
// that fetch has waited long enough and must win the next contested cycle.
module imem_dmem_arbiter_starve_ctr
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic sat_o
);

  localparam int CNT_W = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment; increment stops at the saturation value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat_o = (cnt == CNT_MAX);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data
// load/store. Data side has priority, but fetch is forced through after
// STARVE_MAX consecutive losses. One transaction in flight at a time.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_be_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                mem_gnt_o,
  output logic                mem_rvalid_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                f_cmiss_o,
  output logic                m_cmiss_o
);

  arb_state_t state, state_nxt;
  arb_owner_t owner, owner_nxt;

  logic sel_if;
  logic sel_mem;
  logic fetch_first;
  logic grant_fire;

  imem_dmem_arbiter_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (bus_gnt_i & sel_mem & if_req_i),
    .clr    (bus_gnt_i & sel_if),
    .sat_o  (fetch_first)
  );

  // Pick a requester in IDLE; fetch only beats data once it is starved.
  always_comb begin
    sel_if  = 1'b0;
    sel_mem = 1'b0;
    if (state == ARB_IDLE) begin
      if (if_req_i && mem_req_i) begin
        sel_if  = fetch_first;
        sel_mem = !fetch_first;
      end else begin
        sel_if  = if_req_i;
        sel_mem = mem_req_i;
      end
    end
  end

  assign grant_fire = bus_gnt_i & (sel_if | sel_mem);

  // State and owner register; reset drops any response still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next state: latch the winner on grant, release the bus on response.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      ARB_IDLE: begin
        if (grant_fire) begin
          state_nxt = ARB_WAIT;
          owner_nxt = sel_mem ? OWN_MEM : OWN_IF;
        end
      end
      ARB_WAIT: begin
        if (bus_rvalid_i) begin
          state_nxt = ARB_IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Bus muxing, grant/response routing and stall flags, all forced low in reset.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_be_o     = '0;
    bus_addr_o   = '0;
    bus_wdata_o  = '0;
    if_gnt_o     = 1'b0;
    mem_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    mem_rvalid_o = 1'b0;
    if_rdata_o   = '0;
    mem_rdata_o  = '0;
    f_cmiss_o    = 1'b0;
    m_cmiss_o    = 1'b0;
    if (resetn) begin
      bus_req_o = sel_if | sel_mem;
      if (sel_mem) begin
        bus_we_o    = mem_we_i;
        bus_be_o    = mem_be_i;
        bus_addr_o  = mem_addr_i;
        bus_wdata_o = mem_wdata_i;
      end else if (sel_if) begin
        bus_be_o   = '1;
        bus_addr_o = if_addr_i;
      end
      if_gnt_o  = bus_gnt_i & sel_if;
      mem_gnt_o = bus_gnt_i & sel_mem;
      if ((state == ARB_WAIT) && bus_rvalid_i) begin
        if (owner == OWN_IF) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = bus_rdata_i;
        end else if (owner == OWN_MEM) begin
          mem_rvalid_o = 1'b1;
          mem_rdata_o  = bus_rdata_i;
        end
      end
      f_cmiss_o = if_req_i & ~if_rvalid_o;
      m_cmiss_o = mem_req_i & ~mem_rvalid_o;
    end
  end

endmodule
